// File: rtl/nrisc_multiciclo.sv
// Multicycle nRisc core: 8-bit instructions, DATA_W datapath, ADDR_W program counter.
// Fetch and load/store share a single req/ack memory port, so wait-state memories work.
module nrisc_multiciclo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_done,
    output logic              halted
);

    localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_BEQZ = 3'd6;
    localparam logic [2:0] OP_JR   = 3'd7;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] result;

    logic [2:0]        opcode;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic [EXT_W-1:0]  a_ext;
    logic [EXT_W-1:0]  b_ext;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] imm_pc;

    assign opcode = ir[7:5];
    assign ra     = ir[4:3];
    assign rb     = ir[2:1];
    // Register values become addresses by truncation, or zero-extension when narrower
    assign a_ext  = EXT_W'(a);
    assign b_ext  = EXT_W'(b);
    assign a_addr = a_ext[ADDR_W-1:0];
    assign b_addr = b_ext[ADDR_W-1:0];
    assign imm_pc = {{(ADDR_W-3){ir[2]}}, ir[2:0]};
    assign pc_out = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            result <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata[7:0];
                        pc <= pc + ADDR_W'(1);
                    end
                end
                DECODE: begin
                    a   <= regs[ra];
                    b   <= regs[rb];
                    imm <= {{(DATA_W-3){ir[2]}}, ir[2:0]};
                end
                EXEC: begin
                    case (opcode)
                        OP_ADD:  result <= a + b;
                        OP_SUB:  result <= a - b;
                        OP_AND:  result <= a & b;
                        OP_ADDI: result <= a + imm;
                        // PC was already advanced past the branch during fetch
                        OP_BEQZ: if (a == '0) pc <= pc + imm_pc;
                        OP_JR:   if (!ir[0]) pc <= a_addr;
                        default: ;
                    endcase
                end
                MEM: begin
                    if (mem_ack && opcode == OP_LD) begin
                        result <= mem_rdata;
                    end
                end
                WB: regs[ra] <= result;
                default: ;
            endcase
        end
    end

    // mem_req is qualified by reset so a pending transaction is dropped the instant reset asserts
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = reset;
                mem_addr = pc;
                if (mem_ack) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                case (opcode)
                    OP_LD, OP_ST: state_next = MEM;
                    OP_BEQZ: begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                    OP_JR: begin
                        instr_done = 1'b1;
                        state_next = ir[0] ? HALT : FETCH;
                    end
                    default: state_next = WB;
                endcase
            end
            MEM: begin
                mem_req  = reset;
                mem_addr = b_addr;
                mem_we   = (opcode == OP_ST);
                if (opcode == OP_ST) mem_wdata = a;
                if (mem_ack) begin
                    instr_done = (opcode == OP_ST);
                    state_next = (opcode == OP_ST) ? FETCH : WB;
                end
            end
            WB: begin
                instr_done = 1'b1;
                state_next = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_nrisc_multiciclo.sv
// Directed bench for nrisc_multiciclo (DATA_W=16, ADDR_W=8) with a wait-state memory model.
// Programs are hand-assembled; expected values are worked out from the ISA by hand.
module tb_nrisc_multiciclo;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [7:0]  pc_out;
    logic        instr_done;
    logic        halted;

    logic [15:0] mem [256];
    int          wait_cycles;
    int          wait_cnt;
    int          total_checks;
    int          passed_checks;
    int          cycle;
    int          write_count;
    logic [7:0]  first_write_addr;
    logic [15:0] first_write_data;
    int          first_run;
    int          run_len;
    int          unstable;
    logic        req_prev;
    logic [7:0]  held_addr;
    logic        held_we;
    logic [15:0] held_wdata;
    int          done_q [$];
    logic [7:0]  fetch_q [$];
    logic [7:0]  prog_a [3];
    logic [7:0]  prog_b [12];
    logic [7:0]  prog_c [9];

    nrisc_multiciclo #(.DATA_W(16), .ADDR_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc_out     (pc_out),
        .instr_done (instr_done),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wait_cnt >= wait_cycles);

    always @(posedge clock) begin
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
        if (mem_req && mem_ack && mem_we) begin
            if (write_count == 0) begin
                first_write_addr = mem_addr;
                first_write_data = mem_wdata;
            end
            write_count = write_count + 1;
            mem[mem_addr] = mem_wdata;
        end
        if (mem_req && mem_ack && !mem_we) fetch_q.push_back(mem_addr);
    end

    // Cycle 1 is the first full cycle after reset release; also watches request stability
    always @(negedge clock) begin
        if (reset) begin
            cycle = cycle + 1;
            if (instr_done) done_q.push_back(cycle);
        end
        if (mem_req) begin
            if (req_prev) begin
                run_len = run_len + 1;
                if (mem_addr != held_addr || mem_we != held_we || mem_wdata != held_wdata)
                    unstable = unstable + 1;
            end else begin
                run_len    = 1;
                held_addr  = mem_addr;
                held_we    = mem_we;
                held_wdata = mem_wdata;
            end
            if (mem_ack && first_run == 0) first_run = run_len;
        end
        req_prev = mem_req && !mem_ack;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks = total_checks + 1;
        if (observed === expected) begin
            passed_checks = passed_checks + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitors;
        cycle       = 0;
        write_count = 0;
        first_run   = 0;
        unstable    = 0;
        req_prev    = 1'b0;
        done_q.delete();
        fetch_q.delete();
    endtask

    task automatic clearMemory;
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Holds reset for a couple of cycles, then releases it just after a rising edge
    task automatic applyStimulus(input int waits);
        reset       = 1'b0;
        wait_cycles = waits;
        @(posedge clock);
        @(negedge clock);
        clearMonitors();
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic runToHalt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clock);
        checkOutput("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b0;
        wait_cycles   = 0;
        total_checks  = 0;
        passed_checks = 0;
        clearMonitors();
        clearMemory();

        prog_a = '{8'h6B, 8'h0A, 8'hE1};
        prog_b = '{8'h73, 8'h14, 8'h14, 8'h14, 8'h8C, 8'h71,
                   8'hAC, 8'h9C, 8'h79, 8'h71, 8'hBC, 8'hE1};
        prog_c = '{8'h6B, 8'h0A, 8'hC1, 8'h61, 8'hC6, 8'h38, 8'hBA, 8'hAE, 8'hF8};

        repeat (2) @(negedge clock);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_pc", 32'(pc_out), 32'd0);
        checkOutput("rst_addr_wdata", {8'(mem_addr), 16'(mem_wdata), 7'd0, mem_we}, 32'd0);
        checkOutput("rst_done_halt", {30'd0, instr_done, halted}, 32'd0);

        $display("[TB] program A: ADDI/ADD/HALT, zero-wait memory");
        foreach (prog_a[i]) mem[i] = 16'(prog_a[i]);
        applyStimulus(0);
        runToHalt(60);
        checkOutput("a_done_count", 32'(done_q.size()), 32'd3);
        if (done_q.size() == 3) begin
            checkOutput("a_done_cycle0", 32'(done_q[0]), 32'd4);
            checkOutput("a_done_cycle1", 32'(done_q[1]), 32'd8);
            checkOutput("a_done_cycle2", 32'(done_q[2]), 32'd11);
        end
        @(negedge clock);
        checkOutput("a_halt_no_req", 32'(mem_req), 32'd0);

        $display("[TB] program B: LD/ST with 3 wait states");
        clearMemory();
        foreach (prog_b[i]) mem[i] = 16'(prog_b[i]);
        mem[8'h18] = 16'h005A;
        applyStimulus(3);
        runToHalt(400);
        checkOutput("b_first_req_len", 32'(first_run), 32'd4);
        checkOutput("b_req_stable", 32'(unstable), 32'd0);
        checkOutput("b_write_count", 32'(write_count), 32'd2);
        checkOutput("b_first_wr_addr", 32'(first_write_addr), 32'h19);
        checkOutput("b_first_wr_data", 32'(first_write_data), 32'h5A);
        checkOutput("b_mem19", 32'(mem[8'h19]), 32'h5A);
        checkOutput("b_mem1a", 32'(mem[8'h1A]), 32'h5B);

        $display("[TB] program C: BEQZ taken/not taken, SUB wrap, JR wrap");
        clearMemory();
        foreach (prog_c[i]) mem[i] = 16'(prog_c[i]);
        applyStimulus(0);
        for (int i = 0; i < 200 && fetch_q.size() < 12; i++) @(negedge clock);
        checkOutput("c_fetch_count", 32'(fetch_q.size() >= 12), 32'd1);
        if (fetch_q.size() >= 12) begin
            checkOutput("c_beqz_skip", 32'(fetch_q[3]), 32'h04);
            checkOutput("c_beqz_taken", 32'(fetch_q[4]), 32'h03);
            checkOutput("c_beqz_not_taken", 32'(fetch_q[6]), 32'h05);
            checkOutput("c_jr_target", 32'(fetch_q[10]), 32'hFF);
            checkOutput("c_pc_wrap", 32'(fetch_q[11]), 32'h00);
        end
        checkOutput("c_sub_wrap", 32'(mem[8'h06]), 32'hFFFF);
        checkOutput("c_r1_value", 32'(mem[8'hFF]), 32'h0006);

        $display("[TB] program B again: reset during a store");
        clearMemory();
        foreach (prog_b[i]) mem[i] = 16'(prog_b[i]);
        mem[8'h18] = 16'h005A;
        applyStimulus(3);
        for (int i = 0; i < 300 && !(mem_req && mem_we); i++) @(negedge clock);
        checkOutput("r_store_reached", 32'(mem_req && mem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("r_req_drop", 32'(mem_req), 32'd0);
        checkOutput("r_pc_zero", 32'(pc_out), 32'd0);
        checkOutput("r_we_zero", 32'(mem_we), 32'd0);
        @(posedge clock);
        checkOutput("r_no_write", 32'(mem[8'h19]), 32'd0);
        clearMonitors();
        #1 reset = 1'b1;
        runToHalt(400);
        checkOutput("r_first_fetch", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hDEAD, 32'd0);
        checkOutput("r_write_count", 32'(write_count), 32'd2);
        checkOutput("r_mem19", 32'(mem[8'h19]), 32'h5A);
        checkOutput("r_mem1a", 32'(mem[8'h1A]), 32'h5B);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
